// File: rtl/cam_capture_rgb444.sv
// OV7670-style camera receiver: oversamples pclk/vsync/href/data in the clk domain and writes RGB444 pixels to a frame buffer.
// Optional line/frame length checking is built when CAM_CAPTURE_CHECK_EN is defined.
module cam_capture_rgb444 #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int AW          = 15,
  parameter int DW          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_px_data,
  input  logic          cap_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          frame_done,
  output logic          busy,
  output logic [1:0]    cap_err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int LINE_BYTES = 2 * IMG_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic [10:0] s_bus;
  logic        s_pclk, s_vsync, s_href;
  logic [7:0]  s_data;
  logic        pclk_prev, vsync_prev;
  logic        pclk_rise, vsync_rise, vsync_fall;

  logic        start_frame, end_frame, in_frame, byte_ok, latch_r, latch_gb;
  logic [3:0]  red;
  logic [DW-1:0] pix;
  logic        wr_req, full;

  // All camera signals share one chain so pclk, href and data stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], {cam_pclk, cam_vsync, cam_href, cam_px_data}};
      pclk_prev  <= s_pclk;
      vsync_prev <= s_vsync;
    end
  end

  assign s_bus      = sync_q[SYNC_STAGES-1];
  assign s_pclk     = s_bus[10];
  assign s_vsync    = s_bus[9];
  assign s_href     = s_bus[8];
  assign s_data     = s_bus[7:0];
  assign pclk_rise  = s_pclk & ~pclk_prev;
  assign vsync_rise = s_vsync & ~vsync_prev;
  assign vsync_fall = ~s_vsync & vsync_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (cap_en) next_state = WAIT_FRAME;
      WAIT_FRAME: if (vsync_fall && cap_en) next_state = WAIT_LINE;
      WAIT_LINE, BYTE_HI, BYTE_LO: begin
        if (vsync_rise)      next_state = cap_en ? WAIT_FRAME : IDLE;
        else if (pclk_rise) begin
          if (!s_href)                next_state = WAIT_LINE;
          else if (state == BYTE_HI)  next_state = BYTE_LO;
          else                        next_state = BYTE_HI;
        end
      end
      default:    next_state = IDLE;
    endcase
  end

  // A vsync rise takes priority over a byte arriving in the same clk.
  always_comb begin
    in_frame    = (state == WAIT_LINE) || (state == BYTE_HI) || (state == BYTE_LO);
    start_frame = (state == WAIT_FRAME) && vsync_fall && cap_en;
    end_frame   = in_frame && vsync_rise;
    byte_ok     = in_frame && !vsync_rise && pclk_rise && s_href;
    latch_r     = byte_ok && (state != BYTE_HI);
    latch_gb    = byte_ok && (state == BYTE_HI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red        <= '0;
      pix        <= '0;
      wr_req     <= 1'b0;
      full       <= 1'b0;
      mem_we     <= 1'b0;
      mem_data   <= '0;
      mem_addr   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_req     <= latch_gb;
      mem_we     <= wr_req && !full;
      frame_done <= end_frame;
      if (latch_r)  red <= s_data[3:0];
      if (latch_gb) pix <= DW'({red, s_data});
      if (wr_req && !full) mem_data <= pix;
      // Address saturates at the last pixel; full blocks any further writes.
      if (start_frame) begin
        mem_addr <= '0;
        full     <= 1'b0;
      end else if (mem_we) begin
        if (mem_addr == LAST_ADDR) full <= 1'b1;
        else                       mem_addr <= mem_addr + AW'(1);
      end
      if (start_frame)    busy <= 1'b1;
      else if (end_frame) busy <= 1'b0;
    end
  end

`ifdef CAM_CAPTURE_CHECK_EN
  localparam int BCW = $clog2(LINE_BYTES + 1) + 1;
  localparam int LCW = $clog2(IMG_H + 1) + 1;

  logic [BCW-1:0] byte_cnt;
  logic [LCW-1:0] line_cnt, lines_at_end;
  logic [1:0]     err;
  logic           mid_line, line_end;

  assign mid_line     = (state == BYTE_HI) || (state == BYTE_LO);
  assign line_end     = mid_line && !vsync_rise && pclk_rise && !s_href;
  assign lines_at_end = (mid_line && line_cnt != '1) ? line_cnt + LCW'(1) : line_cnt;

  // A line cut short by vsync still counts as a line for the frame total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      err      <= 2'b00;
    end else if (start_frame) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      err      <= 2'b00;
    end else begin
      if (byte_ok && byte_cnt != '1) byte_cnt <= byte_cnt + BCW'(1);
      if (line_end || end_frame)     byte_cnt <= '0;
      if (line_end) begin
        if (byte_cnt != BCW'(LINE_BYTES)) err[0] <= 1'b1;
        if (line_cnt != '1)               line_cnt <= line_cnt + LCW'(1);
      end
      if (end_frame) begin
        if (mid_line && byte_cnt != BCW'(LINE_BYTES)) err[0] <= 1'b1;
        if (lines_at_end != LCW'(IMG_H))              err[1] <= 1'b1;
      end
      if (wr_req && full) err[1] <= 1'b1;
    end
  end

  assign cap_err = err;
`else
  assign cap_err = 2'b00;
`endif

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Scoreboard bench for cam_capture_rgb444 using a reduced 8x6 image so every frame stays short.
module tb_cam_capture_rgb444;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int AW   = 15;
  localparam int DW   = 12;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b1;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_px_data = 8'h00;
  logic          cap_en = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          frame_done;
  logic          busy;
  logic [1:0]    cap_err;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;
  int   exp_addr = 0;
  bit   capturing = 1'b0;

  cam_capture_rgb444 #(
    .IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_px_data(cam_px_data), .cap_en(cap_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .frame_done(frame_done), .busy(busy), .cap_err(cap_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write must match the oldest expected pixel.
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr %0d data %03h, none expected", mem_addr, mem_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_data !== e.data) begin
          errors++;
          $display("[TB] FAIL write: got addr %0d data %03h, expected addr %0d data %03h",
                   mem_addr, mem_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One camera byte with pclk at clk/4; data changes on pclk fall, expectation queued before the rise.
  task automatic camCycle(input logic href, input logic [7:0] data, input bit push, input logic [DW-1:0] pix);
    @(negedge clk);
    cam_href = href; cam_px_data = data; cam_pclk = 1'b0;
    @(negedge clk);
    if (push && capturing) begin
      if (exp_addr < NPIX) exp_q.push_back('{addr: AW'(exp_addr), data: pix});
      exp_addr++;
    end
    @(negedge clk);
    cam_pclk = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: 00,0F,00,0F,00,F0,00,F0 -> 00F,00F,0F0,0F0; mode 1: hi={5,p}, lo={line,~p} -> {p,line,~p}
  task automatic driveLine(input int line, input int nbytes, input int mode);
    logic [7:0]    b;
    logic [DW-1:0] pix;
    logic [3:0]    pn, ln;
    for (int i = 0; i < nbytes; i++) begin
      pn = 4'(i / 2);
      ln = 4'(line);
      if (mode == 0) begin
        case (i % 8)
          1, 3:    b = 8'h0F;
          5, 7:    b = 8'hF0;
          default: b = 8'h00;
        endcase
        pix = ((i / 2) % 4 < 2) ? 12'h00F : 12'h0F0;
      end else begin
        b   = (i % 2 == 0) ? {4'h5, pn} : {ln, ~pn};
        pix = {pn, ln, ~pn};
      end
      camCycle(1'b1, b, (i % 2) == 1, pix);
    end
    camCycle(1'b0, 8'hAA, 1'b0, '0);
    camCycle(1'b0, 8'h55, 1'b0, '0);
  endtask

  task automatic applyStimulus(input int nlines, input int short_line, input int short_bytes,
                               input int mode, input int cut_line, input int rst_line);
    fd_count = 0;
    cam_vsync = 1'b1;
    repeat (3) camCycle(1'b0, 8'h00, 1'b0, '0);
    cam_vsync = 1'b0;
    exp_addr = 0;
    repeat (2) camCycle(1'b0, 8'h00, 1'b0, '0);
    for (int l = 0; l < nlines; l++) begin
      if (l == cut_line) cap_en = 1'b0;
      if (l == rst_line) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_addr", int'(mem_addr), 0);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_we", int'(mem_we), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        capturing = 1'b0;
      end
      driveLine(l, (l == short_line) ? short_bytes : 2 * W, mode);
      if (l == 0 && capturing) checkOutput("busy_in_frame", int'(busy), 1);
    end
    cam_vsync = 1'b1;
    repeat (2) camCycle(1'b0, 8'h00, 1'b0, '0);
    repeat (4) @(negedge clk);
  endtask

  task automatic endOfFrame(input string tag, input int fd, input int addr, input int err_chk);
    checkOutput({tag, "_frame_done"}, fd_count, fd);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
    checkOutput({tag, "_addr"}, int'(mem_addr), addr);
`ifdef CAM_CAPTURE_CHECK_EN
    checkOutput({tag, "_cap_err"}, int'(cap_err), err_chk);
`else
    checkOutput({tag, "_cap_err"}, int'(cap_err), err_chk & 0);
`endif
  endtask

  initial begin
    // Reset held while the camera is active
    repeat (3) camCycle(1'b1, 8'h3C, 1'b0, '0);
    cam_vsync = 1'b0;
    cap_en = 1'b1;
    repeat (3) camCycle(1'b1, 8'hC3, 1'b0, '0);
    checkOutput("reset_we", int'(mem_we), 0);
    checkOutput("reset_addr", int'(mem_addr), 0);
    checkOutput("reset_data", int'(mem_data), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_frame_done", int'(frame_done), 0);
    checkOutput("reset_cap_err", int'(cap_err), 0);
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    capturing = 1'b1;
    applyStimulus(H, -1, 0, 0, -1, -1);
    endOfFrame("full_spec", 1, NPIX - 1, 0);

    capturing = 1'b1;
    applyStimulus(H, 2, 2 * W - 1, 1, -1, -1);
    endOfFrame("odd_line", 1, NPIX - 1, 1);

    capturing = 1'b1;
    applyStimulus(H + 1, -1, 0, 1, -1, -1);
    endOfFrame("extra_line", 1, NPIX - 1, 2);

    capturing = 1'b1;
    applyStimulus(H, -1, 0, 1, 3, -1);
    endOfFrame("cap_en_cut", 1, NPIX - 1, 0);

    capturing = 1'b0;
    applyStimulus(H, -1, 0, 1, -1, -1);
    endOfFrame("idle_frame", 0, NPIX - 1, 0);

    cap_en = 1'b1;
    capturing = 1'b1;
    applyStimulus(H, -1, 0, 1, -1, 2);
    endOfFrame("reset_frame", 0, 0, 0);

    capturing = 1'b1;
    applyStimulus(H, -1, 0, 0, -1, -1);
    endOfFrame("after_reset", 1, NPIX - 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
